// File: rtl/snes_poller.sv
// Console-side SNES pad reader: drives latch/clock, shifts in 16 serial bits LSB-first
// and presents the inverted (active-high) button word once per completed frame.
module snes_poller #(
  parameter int NUM_BITS      = 16,
  parameter int LATCH_WIDTH   = 24,
  parameter int HALF_PERIOD   = 12,
  parameter int POLL_INTERVAL = 33333
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                snes_data,
  output logic                snes_latch,
  output logic                snes_clk,
  output logic [NUM_BITS-1:0] buttons,
  output logic                valid,
  output logic                busy
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LATCH    = 3'd1;
  localparam logic [2:0] GAP      = 3'd2;
  localparam logic [2:0] CLK_LOW  = 3'd3;
  localparam logic [2:0] CLK_HIGH = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

  localparam int TMAX = (LATCH_WIDTH > HALF_PERIOD) ? LATCH_WIDTH : HALF_PERIOD;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int BW   = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam int IW   = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;

  logic                data_p0, data_p1;
  logic [IW-1:0]       ival;
  logic                expire;
  logic                trigger;
  logic [2:0]          state, state_n;
  logic [TW-1:0]       timer;
  logic                tdone;
  logic [BW-1:0]       bit_idx;
  logic [NUM_BITS-1:0] shift_reg;

  // Stage p0/p1: two-flop synchronizer for the pad's asynchronous data line
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_p0 <= 1'b1;
      data_p1 <= 1'b1;
    end else begin
      data_p0 <= snes_data;
      data_p1 <= data_p0;
    end
  end

  // Free-running interval counter; expiries outside IDLE are simply lost
  always_comb expire = (POLL_INTERVAL != 0) && (ival == IW'(POLL_INTERVAL - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                   ival <= '0;
    else if (POLL_INTERVAL == 0) ival <= '0;
    else if (expire)             ival <= '0;
    else                         ival <= ival + 1'b1;
  end

  always_comb trigger = (state == IDLE) && (start || expire);
  always_comb tdone   = (timer == '0);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (trigger) state_n = LATCH;
      LATCH:    if (tdone)   state_n = GAP;
      GAP:      if (tdone)   state_n = CLK_LOW;
      CLK_LOW:  if (tdone)   state_n = CLK_HIGH;
      CLK_HIGH: if (tdone)   state_n = (bit_idx == BW'(NUM_BITS - 1)) ? DONE : CLK_LOW;
      DONE:                  state_n = IDLE;
      default:               state_n = IDLE;
    endcase
  end

  // Pad outputs are registered from the next state so they never glitch
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      buttons    <= '0;
      snes_latch <= 1'b0;
      snes_clk   <= 1'b1;
    end else begin
      state      <= state_n;
      snes_latch <= (state_n == LATCH);
      snes_clk   <= (state_n != CLK_LOW);
      if (state_n != state)
        timer <= (state_n == LATCH) ? TW'(LATCH_WIDTH - 1) : TW'(HALF_PERIOD - 1);
      else if (!tdone)
        timer <= timer - 1'b1;
      if (trigger) begin
        bit_idx   <= '0;
        shift_reg <= '0;
      end
      // Capture on the first cycle of the low phase, after a full high phase of settling
      if (state == CLK_LOW && timer == TW'(HALF_PERIOD - 1))
        shift_reg <= {data_p1, shift_reg[NUM_BITS-1:1]};
      if (state == CLK_HIGH && tdone)
        bit_idx <= bit_idx + 1'b1;
      // Whole-frame update so a partial word is never visible
      if (state_n == DONE && state != DONE)
        buttons <= ~shift_reg;
    end
  end

  assign valid = (state == DONE);
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_snes_poller.sv
// Randomized scoreboard bench for snes_poller with a behavioural pad and a timing model
// derived from trigger time arithmetic.
module tb_snes_poller;
  localparam int NB  = 16;
  localparam int LW  = 24;
  localparam int HP  = 12;
  localparam int PI  = 1000;
  localparam int LAT = LW + HP + 2 * HP * NB;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          snes_data = 1'b1;
  logic          snes_latch, snes_clk, valid, busy;
  logic [NB-1:0] buttons;

  always #5 clock = ~clock;

  snes_poller #(.NUM_BITS(NB), .LATCH_WIDTH(LW), .HALF_PERIOD(HP), .POLL_INTERVAL(PI)) dut (
    .clock(clock), .reset(reset), .start(start), .snes_data(snes_data),
    .snes_latch(snes_latch), .snes_clk(snes_clk), .buttons(buttons),
    .valid(valid), .busy(busy)
  );

  // Pad: parallel load while latched, shift on each rising clock, low = pressed
  logic [NB-1:0] pad_word = 16'hFFFF;
  logic [NB-1:0] pad_sh   = 16'hFFFF;
  always @(posedge snes_latch or posedge snes_clk) begin
    if (snes_latch) pad_sh = pad_word;
    else            pad_sh = {1'b1, pad_sh[NB-1:1]};
    snes_data = pad_sh[0];
  end

  typedef struct {
    int            edge_n;
    logic [NB-1:0] want;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int fails  = 0;
  int ecount = 0;
  int kk     = 0;
  int trig_e = -100000;
  int n_valid = 0;
  logic [NB-1:0] btn_exp = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (edge %0d)", name, got, want, ecount);
    end
  endtask

  // Reference model: decides trigger edges from the start/interval rules
  always @(posedge clock) begin
    bit expiry;
    ecount++;
    if (reset) begin
      kk = 0;
      trig_e = -100000;
      sb.delete();
    end else begin
      expiry = ((kk % PI) == PI - 1);
      kk++;
      if ((start || expiry) && ecount > trig_e + LAT + 1) begin
        trig_e = ecount;
        sb.push_back('{edge_n: ecount + LAT, want: ~pad_word});
      end
    end
  end

  // Monitor: per-cycle pin expectations plus scoreboard pop on valid
  logic prev_clk = 1'b1;
  int   falls = 0;
  int   lhigh = 0;
  always @(negedge clock) begin
    int   p;
    bit   busy_e, lat_e, clk_e;
    exp_t h;
    if (reset) begin
      falls = 0;
      lhigh = 0;
      prev_clk = 1'b1;
      btn_exp = '0;
    end else begin
      p      = ecount - trig_e;
      busy_e = (p >= 0) && (p <= LAT);
      lat_e  = (p >= 0) && (p < LW);
      clk_e  = !((p >= LW + HP) && (p < LAT) && (((p - LW - HP) % (2 * HP)) < HP));
      chk("busy", 32'(busy), 32'(busy_e));
      chk("snes_latch", 32'(snes_latch), 32'(lat_e));
      chk("snes_clk", 32'(snes_clk), 32'(clk_e));
      chk("valid", 32'(valid), 32'(p == LAT));
      if (prev_clk && !snes_clk) falls++;
      prev_clk = snes_clk;
      if (snes_latch) lhigh++;
      if (valid) begin
        n_valid++;
        chk("pending_expectation", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          h = sb.pop_front();
          btn_exp = h.want;
          chk("valid_edge", 32'(ecount), 32'(h.edge_n));
          chk("clk_falls_per_poll", 32'(falls), 32'(NB));
          chk("latch_cycles_per_poll", 32'(lhigh), 32'(LW));
        end
        falls = 0;
        lhigh = 0;
      end else if (sb.size() > 0 && ecount > sb[0].edge_n) begin
        chk("valid_overdue", 32'(valid), 32'd1);
        void'(sb.pop_front());
      end
      chk("buttons", 32'(buttons), 32'(btn_exp));
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      if (!busy && sb.size() == 0) return;
      @(negedge clock);
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic do_poll(input logic [NB-1:0] w);
    wait_idle();
    pad_word = w;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    wait_idle();
  endtask

  initial begin
    int lows, base, bound_hit;
    logic pclk;
    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset_latch", 32'(snes_latch), 32'd0);
    chk("reset_clk", 32'(snes_clk), 32'd1);
    chk("reset_buttons", 32'(buttons), 32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    do_poll(16'hFFFE);
    do_poll(16'hF0A5);
    do_poll(16'hFFFF);
    do_poll(16'h0000);
    for (int i = 0; i < 6; i++) do_poll(16'($urandom));
    do_poll(16'h5A5A);

    // Reset during the 8th low phase of a frame that would read 16'h00FF
    wait_idle();
    pad_word = 16'hFF00;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lows = 0;
    pclk = 1'b1;
    for (int i = 0; i < 600 && lows < 8; i++) begin
      @(negedge clock);
      if (pclk && !snes_clk) lows++;
      pclk = snes_clk;
    end
    chk("eighth_low_reached", 32'(lows), 32'd8);
    #2 reset = 1'b1;
    #1;
    chk("midreset_latch", 32'(snes_latch), 32'd0);
    chk("midreset_clk", 32'(snes_clk), 32'd1);
    chk("midreset_buttons", 32'(buttons), 32'd0);
    chk("midreset_valid", 32'(valid), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    base = n_valid;
    repeat (600) @(negedge clock);
    chk("no_valid_after_reset", 32'(n_valid - base), 32'd0);
    chk("buttons_cleared", 32'(buttons), 32'd0);
    do_poll(16'hFF00);

    // start coinciding with interval expiry
    wait_idle();
    bound_hit = 1;
    for (int i = 0; i < 1100; i++) begin
      if ((kk % PI) == PI - 1) begin bound_hit = 0; break; end
      @(negedge clock);
    end
    chk("expiry_alignment_found", 32'(bound_hit), 32'd0);
    base = n_valid;
    pad_word = 16'($urandom);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    wait_idle();
    chk("single_poll_on_double_trigger", 32'(n_valid - base), 32'd1);

    // Autonomous polling with stray start pulses while busy
    base = n_valid;
    for (int i = 0; i < 3500; i++) begin
      @(negedge clock);
      start = 1'b0;
      if (valid) pad_word = 16'($urandom);
      else if (busy && $urandom_range(0, 40) == 0) start = 1'b1;
    end
    start = 1'b0;
    chk("auto_polls_seen", 32'((n_valid - base) >= 3), 32'd1);
    wait_idle();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/snes_poller.md
Name: snes_poller

Overview:
- Console-side SNES controller interface.
- Drives latch and clock to a physical SNES pad, shifts in its serial data, and presents a debounced-by-frame, active-high button word.
- It is the counterpart of snes_encoder and is used to read a real pad into the button mux path, or to loop back and check the encoder on the bench.
- Polls periodically on its own, or on request.

Parameters:
- NUM_BITS, 16, bits shifted per poll (SNES standard 16; bits 12-15 read 1 on a genuine pad).
- LATCH_WIDTH, 24, clock cycles latch is held high (~12 us at 2.08 MHz).
- HALF_PERIOD, 12, clock cycles per half of snes_clk (~6 us); must be >= 3.
- POLL_INTERVAL, 33333, clock cycles between automatic polls (~16 ms); 0 = auto polling off.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a poll; sampled only in IDLE.
- snes_data  input  1  serial data from pad; low = pressed; asynchronous to clock.
- snes_latch  output  1  latch to pad, active high.
- snes_clk  output  1  shift clock to pad, idles high.
- buttons  output  NUM_BITS  last completed frame; active high; bit 0 = first bit shifted (B).
- valid  output  1  one-cycle pulse when buttons updates.
- busy  output  1  high from trigger cycle until the valid cycle inclusive.

Behaviour:
- Reset values:
  - snes_latch=0, snes_clk=1, buttons=0, valid=0, busy=0.
  - Interval counter=0, FSM in IDLE, shift register=0.
- Synchronizer: snes_data passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- Trigger (cycle T):
  - In IDLE, start=1 triggers a poll.
  - When POLL_INTERVAL != 0, the interval counter reaching POLL_INTERVAL-1 also triggers a poll. The counter then wraps to 0.
  - The interval counter runs continuously, including while busy.
  - An interval expiry while not in IDLE is dropped, not queued. start while busy is ignored.
  - Both trigger sources in the same cycle give a single poll.
- FSM states: IDLE -> LATCH -> GAP -> CLK_LOW <-> CLK_HIGH -> DONE -> IDLE.
  - LATCH: cycles T+1..T+LATCH_WIDTH; snes_latch=1, snes_clk=1.
  - GAP: HALF_PERIOD cycles; snes_latch=0, snes_clk=1. Bit 0 settles during this state.
  - CLK_LOW: HALF_PERIOD cycles, snes_clk=0.
    - On its first cycle, capture the synchronized data bit i, shifting it into position i (LSB-first).
  - CLK_HIGH: HALF_PERIOD cycles, snes_clk=1. The pad shifts the next bit on this rising edge.
  - After the CLK_HIGH of bit NUM_BITS-1, go to DONE.
  - DONE (1 cycle):
    - buttons <= ~shift_reg (inversion to active high).
    - valid=1, busy=1.
    - Next state IDLE.
- Latency: valid is asserted at T+1+LATCH_WIDTH+HALF_PERIOD+2*HALF_PERIOD*NUM_BITS. This is T+421 with defaults.
- busy and idle levels:
  - busy=1 on cycles T+1 through the valid cycle.
  - snes_latch and snes_clk are exactly 0 and 1 in IDLE.
- buttons update rules:
  - buttons changes only in DONE and is stable otherwise.
  - A poll never exposes a partially shifted word.
- Disconnected pad (data floats/pulled high): all bits read 1, so buttons=0. No error flag.
- Reset mid-poll:
  - Immediately (asynchronously) forces the reset values.
  - The partial frame is discarded and buttons clears to 0.
  - No valid pulse.
- Exactly NUM_BITS falling edges of snes_clk per poll. No extra edges at the end of a frame or in IDLE.

Test Plan:
- Reset, then start=1 for 1 cycle at T, with a pad model driving 16'b1111_1111_1111_1110 (bit 0 low) -> latch high T+1..T+24; 16 snes_clk low pulses of 12 cycles; buttons=16'h0001 with valid at T+421; busy low at T+422.
- Pad model returns 16'hF0A5 (raw) -> buttons=16'h0F5A. Also loop back through snes_encoder with d=8'h3C -> buttons[7:0]=8'h3C.
- POLL_INTERVAL=1000 in simulation, start tied low -> triggers every 1000 cycles and one valid per trigger. Pulse start during busy -> no extra poll; edge count per poll = 16.
- snes_data held high (no pad) -> buttons=0 after valid. Then a pad pressing all keys (data held 0) -> buttons=16'hFFFF.
- Assert reset at the 8th snes_clk low phase of a poll that would read 16'h00FF -> outputs return to reset values in the same cycle; buttons stays 0; no valid until a fresh start gives the full frame.
- start and interval expiry in the same cycle -> exactly one latch pulse and one valid.
